// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled mid-bit sampling, 2-FF input synchronizer
// and single-cycle valid/framing-error pulses.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       RxD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_TC = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_TC = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t          r_state;
  logic            r_sync1;
  logic            r_rxd_s;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_err;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [CW-1:0]   w_cnt_inc;
  logic [2:0]      w_idx_nxt;
  logic [7:0]      w_shift_nxt;
  logic [7:0]      w_data_nxt;
  logic            w_valid_nxt;
  logic            w_err_nxt;

  assign w_cnt_inc = r_cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rxd_s <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_sync1 <= RxD;
      r_rxd_s <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Counter phase is set by the start edge; every later sample lands mid-bit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rxd_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
        end
      end
      S_START: begin
        if (rx_en) begin
          if (r_cnt == HALF_TC) begin
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_state_nxt = r_rxd_s ? S_IDLE : S_DATA;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      S_DATA: begin
        if (rx_en) begin
          if (r_cnt == FULL_TC) begin
            w_cnt_nxt   = '0;
            w_shift_nxt = {r_rxd_s, r_shift[7:1]};
            w_idx_nxt   = r_idx + 3'd1;
            if (r_idx == 3'd7) w_state_nxt = S_STOP;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      S_STOP: begin
        if (rx_en) begin
          if (r_cnt == FULL_TC) begin
            w_cnt_nxt = '0;
            if (r_rxd_s) begin
              w_data_nxt  = r_shift;
              w_valid_nxt = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = S_WAIT_HIGH;
            end
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (r_rxd_s) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign rx_data  = r_data;
  assign rx_valid = r_valid;
  assign rx_err   = r_err;
  assign rx_busy  = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serial-line driver pushes the expected byte or
// framing error per frame; a negedge monitor pops and compares on each pulse.
module tb_uart_rx;
  localparam int OS      = 16;
  localparam int TICK_P  = 4;
  localparam int BIT_NOM = OS * TICK_P;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_en = 1'b0;
  logic       RxD = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       rx_busy;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] last_good = 8'h00;
  int         errors = 0;
  int         checks = 0;
  int         busy_run = 0;
  int         last_busy_len = 0;
  logic       prev_pulse = 1'b0;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .RxD(RxD),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      rx_en = (n == TICK_P - 1);
      n = (n == TICK_P - 1) ? 0 : n + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid || rx_err) begin
        checks++;
        if (rx_valid && rx_err) begin
          errors++;
          $display("FAIL both_pulses valid=%0b err=%0b required=exclusive", rx_valid, rx_err);
        end
        checks++;
        if (prev_pulse) begin
          errors++;
          $display("FAIL pulse_width second consecutive pulse cycle, required=1 cycle");
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse valid=%0b err=%0b data=%02h required=none",
                   rx_valid, rx_err, rx_data);
        end else begin
          mon_e = exp_q.pop_front();
          checks++;
          if (rx_err !== mon_e.is_err) begin
            errors++;
            $display("FAIL pulse_kind err=%0b required err=%0b", rx_err, mon_e.is_err);
          end
          checks++;
          if (rx_data !== mon_e.data) begin
            errors++;
            $display("FAIL rx_data actual=%02h required=%02h", rx_data, mon_e.data);
          end
        end
      end
      prev_pulse = rx_valid | rx_err;
      if (rx_busy) busy_run++;
      else if (busy_run != 0) begin
        last_busy_len = busy_run;
        busy_run = 0;
      end
    end else begin
      prev_pulse = 1'b0;
      busy_run = 0;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic idle_line(input int clks);
    RxD = 1'b1;
    repeat (clks) @(negedge clk);
  endtask

  // abort_bit >= 0 resets the DUT mid-way through that data bit and ends the frame.
  task automatic send(input logic [7:0] d, input logic stop_v, input int bitp,
                      input int abort_bit, input int extra_low);
    logic [9:0] fr;
    exp_t       e;
    fr = {stop_v, d, 1'b0};
    if (abort_bit < 0) begin
      e.is_err = ~stop_v;
      e.data   = stop_v ? d : last_good;
      exp_q.push_back(e);
      if (stop_v) last_good = d;
    end
    for (int i = 0; i < 10; i++) begin
      RxD = fr[i];
      if (abort_bit >= 0 && i == abort_bit + 1) begin
        repeat (bitp / 2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        RxD = 1'b1;
        rst = 1'b0;
        last_good = 8'h00;
        return;
      end
      repeat (bitp) @(negedge clk);
    end
    if (extra_low > 0) begin
      RxD = 1'b0;
      repeat (extra_low / 2) @(negedge clk);
      chk("wait_high_not_busy", int'(rx_busy), 0);
      repeat (extra_low - extra_low / 2) @(negedge clk);
    end
    RxD = 1'b1;
  endtask

  initial begin
    int bp;
    logic bad;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_rx_err", int'(rx_err), 0);
    chk("reset_rx_busy", int'(rx_busy), 0);
    idle_line(BIT_NOM);

    send(8'hA5, 1'b1, BIT_NOM, -1, 0);
    idle_line(BIT_NOM);
    checks++;
    if (last_busy_len < 600 || last_busy_len > 612) begin
      errors++;
      $display("FAIL busy_length actual=%0d required=600..612", last_busy_len);
    end

    RxD = 1'b0;
    repeat (3 * TICK_P) @(negedge clk);
    idle_line(2 * BIT_NOM);
    chk("glitch_data_kept", int'(rx_data), int'(last_good));
    chk("glitch_not_busy", int'(rx_busy), 0);

    send(8'h3C, 1'b0, BIT_NOM, -1, 0);
    idle_line(BIT_NOM);
    send(8'h81, 1'b1, BIT_NOM, -1, 0);
    idle_line(BIT_NOM);

    send(8'h00, 1'b0, BIT_NOM, -1, 40 * BIT_NOM);
    idle_line(BIT_NOM);

    send(8'h00, 1'b1, BIT_NOM, -1, 0);
    send(8'hFF, 1'b1, BIT_NOM, -1, 0);
    send(8'h55, 1'b1, BIT_NOM, -1, 0);
    idle_line(BIT_NOM);

    send(8'h7E, 1'b1, BIT_NOM, 4, 0);
    @(negedge clk);
    chk("abort_rx_data", int'(rx_data), 0);
    chk("abort_rx_busy", int'(rx_busy), 0);
    chk("abort_rx_valid", int'(rx_valid), 0);
    chk("abort_rx_err", int'(rx_err), 0);
    idle_line(BIT_NOM);
    send(8'h12, 1'b1, BIT_NOM, -1, 0);
    idle_line(BIT_NOM);

    RxD = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    send(8'h5A, 1'b1, BIT_NOM, -1, 0);
    idle_line(BIT_NOM);

    send(8'hC3, 1'b1, BIT_NOM - 2, -1, 0);
    idle_line(BIT_NOM);
    send(8'hC3, 1'b1, BIT_NOM + 2, -1, 0);
    idle_line(BIT_NOM);

    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 2))
        0:       bp = BIT_NOM - 2;
        1:       bp = BIT_NOM;
        default: bp = BIT_NOM + 2;
      endcase
      bad = ($urandom_range(0, 7) == 0);
      send(8'($urandom), ~bad, bp, -1, 0);
      idle_line(bad ? bp + $urandom_range(0, bp) : $urandom_range(0, 2) * (bp / 2));
    end

    idle_line(BIT_NOM);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, sets the number of rx_en ticks per bit period; it SHALL be an even value from 8 to 32.
REQ-002 clk  input  1  system clock (100 MHz on-board), all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 rx_en  input  1  oversampling tick, one single-clock pulse per 1/(OVERSAMPLE x baud) (153.6 kHz for 9600 baud at OVERSAMPLE=16).
REQ-005 RxD  input  1  asynchronous serial input, idle high, 8N1, LSB first.
REQ-006 rx_data  output  8  last correctly framed byte, registered.
REQ-007 rx_valid  output  1  single-clock pulse, rx_data updated with a new byte.
REQ-008 rx_err  output  1  single-clock pulse, framing error (stop bit sampled low).
REQ-009 rx_busy  output  1  high while a frame is being received (states START, DATA, STOP).

Function
REQ-010 RxD SHALL pass through a 2-FF synchronizer with both flops preset to 1; all FSM decisions SHALL use the synchronized value rxd_s.
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP, WAIT_HIGH, each with registered state and a default transition to IDLE for unused encodings.
REQ-012 A tick counter (width ceil(log2(OVERSAMPLE))), a bit index (3 bits) and an 8-bit shift register SHALL be registered; the counter advances only on rx_en.
REQ-013 IDLE: when rxd_s=0, go to START and clear the tick counter; rx_en is not required for this transition.
REQ-014 START: on the rx_en tick that brings the count to OVERSAMPLE/2, sample rxd_s; if 0, go to DATA with counter and bit index cleared; if 1 (glitch), go to IDLE with no output pulse.
REQ-015 DATA: on every OVERSAMPLE-th rx_en tick (mid-bit), shift rxd_s into shift-register bit 7 (right shift, LSB first) and increment the bit index; after the 8th sample, go to STOP with the counter cleared.
REQ-016 STOP: on the OVERSAMPLE-th rx_en tick, sample rxd_s; if 1, load rx_data from the shift register, pulse rx_valid and go to IDLE; if 0, pulse rx_err, leave rx_data unchanged and go to WAIT_HIGH.
REQ-017 WAIT_HIGH: stay until rxd_s=1, then go to IDLE; a break (continuous low) SHALL produce exactly one rx_err.
REQ-018 rx_valid/rx_err SHALL be asserted in the clock cycle after the sampling rx_en tick and SHALL last exactly one clk cycle; they SHALL never be high together.
REQ-019 Latency from the RxD start-bit falling edge to rx_valid SHALL be 9.5 bit periods plus 2 to 3 clk cycles (synchronizer) plus up to 1 tick period.
REQ-020 Back-to-back frames with a single stop bit SHALL be received without loss: the return to IDLE at mid-stop lets the next falling edge be detected.
REQ-021 rx_en asserted while the FSM is in IDLE or WAIT_HIGH SHALL have no effect.
REQ-022 rx_busy SHALL be combinational from state only (no dependence on RxD).

Reset
REQ-023 With rst=1 at a clk edge: state=IDLE, counters=0, shift register=0x00, rx_data=0x00, rx_valid=0, rx_err=0, rx_busy=0, synchronizer=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no rx_valid or rx_err; after release, a line still low SHALL be treated as a new start bit in IDLE.

Verification
REQ-025 Send 0xA5 at 9600 baud (clk 100 MHz, rx_en every 651 clk) -> exactly one rx_valid, rx_data=0xA5, rx_err never high, rx_busy high for about 9.5 bit periods.
REQ-026 Pulse RxD low for 3 rx_en ticks only -> START aborts to IDLE, no rx_valid, no rx_err, rx_data unchanged.
REQ-027 Send 0x3C with the stop bit forced low, then hold high -> one rx_err pulse, rx_data keeps its previous value, FSM in WAIT_HIGH until the line is high, then the next byte 0x81 is received correctly.
REQ-028 Send 0x00, 0xFF, 0x55 back-to-back with 1 stop bit -> three rx_valid pulses with matching data, in order, none lost.
REQ-029 Assert rst during bit 4 of 0x7E -> no pulses, outputs at reset values; the following frame 0x12 is received correctly.
REQ-030 Send 0xC3 with a baud deviation of +/-3% (rx_en period 632 and 670 clk) -> rx_data=0xC3, no rx_err.
